// File: rtl/adc_pkg.sv
// Constants shared with the ADC behavioural model and the capture FSM encoding.
package adc_pkg;

    localparam int ADC_DATA_W   = 10;
    localparam int ADC_PIPE_LAT = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DELAY   = 2'd1,
        CAPTURE = 2'd2,
        FINISH  = 2'd3
    } adc_cap_state_t;

endpackage

// File: rtl/adc_capture.sv
// Acquisition front end: registers the ADC bus, waits out the ADC pipeline latency
// after a start request and writes a (optionally decimated) burst into the sample RAM.
module adc_capture
    import adc_pkg::*;
#(
    parameter int DATA_W  = ADC_DATA_W,
    parameter int ADDR_W  = 13,
    parameter int ADC_LAT = ADC_PIPE_LAT,
    parameter int DEC_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   len,
    input  logic [DEC_W-1:0]  dec,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              busy,
    output logic              done,
    output adc_cap_state_t    dbg_state
);

    localparam int AW1   = ADDR_W + 1;
    localparam int DLY_W = (ADC_LAT > 1) ? $clog2(ADC_LAT) : 1;

    localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(ADC_LAT - 1);
    localparam logic [DLY_W-1:0] DLY_ONE  = DLY_W'(1);
    localparam logic [DEC_W-1:0] DEC_ONE  = DEC_W'(1);
    localparam logic [AW1-1:0]   ADDR_ONE = AW1'(1);

    adc_cap_state_t    state;
    logic [DATA_W-1:0] adc_q;
    logic [DLY_W-1:0]  dly_cnt;
    logic [DEC_W-1:0]  dec_cnt;
    logic [DEC_W-1:0]  dec_l;
    logic [ADDR_W:0]   len_l;
    logic [ADDR_W:0]   addr_cnt;
    logic [ADDR_W:0]   addr_nxt;

    assign addr_nxt  = addr_cnt + ADDR_ONE;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            adc_q <= '0;
        end else begin
            adc_q <= adc_data;
        end
    end

    // Protocol: start is a one-shot request taken only in IDLE (abort wins if both
    // are high); mem_we/mem_addr/mem_data form a write strobe with no backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            dly_cnt  <= '0;
            dec_cnt  <= '0;
            dec_l    <= '0;
            len_l    <= '0;
            addr_cnt <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        len_l    <= len;
                        dec_l    <= dec;
                        addr_cnt <= '0;
                        dec_cnt  <= '0;
                        dly_cnt  <= DLY_LOAD;
                        busy     <= 1'b1;
                        state    <= (len == '0) ? FINISH : DELAY;
                    end
                end
                DELAY: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (dly_cnt == '0) begin
                        state <= CAPTURE;
                    end else begin
                        dly_cnt <= dly_cnt - DLY_ONE;
                    end
                end
                CAPTURE: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        dec_cnt <= (dec_cnt == dec_l) ? '0 : dec_cnt + DEC_ONE;
                        // Only the first sample of each decimation window is stored.
                        if (dec_cnt == '0) begin
                            mem_we   <= 1'b1;
                            mem_addr <= addr_cnt[ADDR_W-1:0];
                            mem_data <= adc_q;
                            addr_cnt <= addr_nxt;
                            if (addr_nxt == len_l) begin
                                state <= FINISH;
                            end
                        end
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    done  <= !abort;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
